spi_module: RTL and testbench
=============================

SPI_MODULE -- requirements
Module: spi_module

Interface
REQ-001 Parameter DDS_AW, default 9, sets the DDS table address width.
REQ-002 Parameter ID_BYTE, default 8'hA5, is the identity byte shifted out on MISO during every command byte.
REQ-003 Port clk, input, 1 bit, system clock; one clock domain only.
REQ-004 Port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-005 Port sck_spi, input, 1 bit, SPI clock, asynchronous to clk.
REQ-006 Port mosi_spi, input, 1 bit, SPI data from the master.
REQ-007 Port ncs_spi, input, 1 bit, SPI chip select, active-low.
REQ-008 Port miso_spi, output, 1 bit, SPI data to the master; driven 0 while ncs_spi is high.
REQ-009 Port q_c, output, 8 bits, control register.
REQ-010 Ports adc_cfg_out, dds_a_cfg_out, dds_b_cfg_out, outputs, 32 bits each, configuration registers.
REQ-011 Ports mem_data (input, 16 bits) and mem_addr (output, 11 bits) form the ADC buffer read port; mem_data is valid 1 clk after mem_addr.
REQ-012 Port trig_addr, input, 12 bits, ADC trigger address.
REQ-013 Ports dds_a_data and dds_b_data (outputs, 8 bits), dds_a_addr and dds_b_addr (outputs, DDS_AW bits), and dds_a_w and dds_b_w (outputs, 1 bit) form the DDS table write ports.

Function
REQ-014 sck_spi, mosi_spi and ncs_spi shall each pass through a 2-flop synchronizer; the master guarantees an sck half-period of at least 4 clk.
REQ-015 SPI mode 0: MOSI sampled on sck rise, MISO updated on sck fall, MSB first; each ncs_spi falling edge starts a new frame and resets the bit counter.
REQ-016 Byte 0 is the command byte: cmd[7] is W (write), cmd[6:0] is the address; MISO shifts out ID_BYTE during this byte, with its MSB valid before the first sck rise.
REQ-017 Config addresses: 0x00 is q_c (data[7:0]), 0x02 adc_cfg, 0x03 dds_a_cfg, 0x04 dds_b_cfg; a config frame is command plus 32 data bits.
REQ-018 Config write (W=1): the register shall update within 4 clk of the 40th sampled sck rise; a frame aborted before 40 bits changes nothing.
REQ-019 Config read (W=0): MISO shifts out the register value MSB first during the 32 data bits; q_c reads as {24'h0, q_c}.
REQ-020 Address 0x01, W=0, is an ADC buffer read: the first 16-bit word is the status {4'h0, trig_addr}, followed by mem_data for mem_addr = 0, 1, 2, ... until ncs_spi rises.
REQ-021 During a buffer read, the next word shall be fetched and latched before the first sck fall of its slot; mem_addr increments once per word, wraps 2047 to 0, and returns to 0 at each new 0x01 command.
REQ-022 Address 0x05 (or 0x06), W=1, is a DDS A (or B) table write: each following byte is driven on dds_x_data at dds_x_addr with a 1-clk dds_x_w pulse; the address starts at 0 per frame, increments after each write, and wraps modulo 2^DDS_AW.
REQ-023 A partial trailing DDS byte shall not be written.
REQ-024 Unknown addresses, and W=1 to 0x01: ignore MOSI and shift zeros after ID_BYTE.
REQ-025 If ncs_spi rises mid-frame: abort, return to idle, keep registers; no write strobes are issued.

Reset
REQ-026 While rst_n is low: q_c=0, all cfg outputs=0, mem_addr=0, DDS addr/data=0, dds_a_w=dds_b_w=0, miso_spi=0, synchronizers and bit counter cleared.
REQ-027 Reset asserted mid-frame aborts the frame; the next frame after release begins at the next ncs_spi falling edge.

Configuration
REQ-028 Macro SPI_READBACK_EN: when defined, config reads return register values per REQ-019.
REQ-029 When SPI_READBACK_EN is undefined, config-read data bits shift as 0; ID_BYTE, buffer reads and writes are unchanged.

Verification
REQ-030 Send 0x82 0x00112233, then 0x83 0xBABEFDCA -> adc_cfg_out=0x00112233, dds_a_cfg_out=0xBABEFDCA, and MISO command byte = 0xA5.
REQ-031 Send 0x02 0x01234567 after REQ-030 -> MISO data 0x00112233 with SPI_READBACK_EN, 0x00000000 without it, and adc_cfg_out is unchanged.
REQ-032 Send 0x01, mem_data={4'hE,1'b0,mem_addr}, trig_addr=0xADF, 11 words clocked -> 0x0ADF, then 0xE000 through 0xE009.
REQ-033 Send 0x85 then bytes 0x11, 0x22 -> two dds_a_w pulses with addr/data 0/0x11 and 1/0x22; dds_b_w stays 0.
REQ-034 Send 0x84 with ncs_spi rising after 20 bits -> dds_b_cfg_out unchanged; a following full 0x80 0x000000AB gives q_c=0xAB.
REQ-035 Assert rst_n low mid-frame -> all outputs return to 0 asynchronously, and the next full frame works.

Source files
------------

// File: rtl/spi_module.sv
// -----------------------------------------------------------------------------
// spi_module
// SPI mode-0 slave running entirely in the clk domain. It gives access to
// configuration registers, an ADC capture buffer read port and two DDS table
// write ports.
//
// Frame format: a command byte {W, addr[6:0]} followed by data.
//   0x00          q_c (data[7:0]), 32 data bits
//   0x02..0x04    adc_cfg / dds_a_cfg / dds_b_cfg, 32 data bits
//   0x01, W=0     ADC buffer read: status {4'h0, trig_addr}, then mem_data words
//   0x05/0x06,W=1 DDS A/B table write, one table entry per following byte
//   anything else ignored; MISO shifts zeros after the identity byte
//
// Optional feature macro: SPI_READBACK_EN. When it is defined, config reads
// return the register contents. When it is undefined, config read data
// shifts out as zeros.
//
// Ports:
//   clk, rst_n                      system clock, async active-low reset
//   sck_spi, mosi_spi, ncs_spi      SPI inputs (asynchronous, synchronized here)
//   miso_spi                        SPI data out, 0 while ncs_spi is high
//   q_c                             8-bit control register
//   adc_cfg_out, dds_a_cfg_out,
//   dds_b_cfg_out                   32-bit configuration registers
//   mem_addr / mem_data             ADC buffer read port (1-clk read latency)
//   trig_addr                       ADC trigger address, reported as status
//   dds_{a,b}_{data,addr,w}         DDS table write ports
// -----------------------------------------------------------------------------
module spi_module #(
    parameter int         DDS_AW  = 9,
    parameter logic [7:0] ID_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck_spi,
    input  logic              mosi_spi,
    input  logic              ncs_spi,
    output logic              miso_spi,
    output logic [7:0]        q_c,
    output logic [31:0]       adc_cfg_out,
    output logic [31:0]       dds_a_cfg_out,
    output logic [31:0]       dds_b_cfg_out,
    input  logic [15:0]       mem_data,
    output logic [10:0]       mem_addr,
    input  logic [11:0]       trig_addr,
    output logic [7:0]        dds_a_data,
    output logic [7:0]        dds_b_data,
    output logic [DDS_AW-1:0] dds_a_addr,
    output logic [DDS_AW-1:0] dds_b_addr,
    output logic              dds_a_w,
    output logic              dds_b_w
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_CFG,
        ST_BUF,
        ST_DDS,
        ST_IGN
    } state_t;

    state_t r_state, w_state_nxt, w_dec_state;

    logic [1:0]        r_sck_sync, r_mosi_sync, r_ncs_sync;
    logic              r_sck_d, r_ncs_d;
    logic              w_sck_rise, w_sck_fall, w_ncs_fall, w_mosi;
    logic [4:0]        r_bit_cnt;
    logic [30:0]       r_shift_in;
    logic [31:0]       r_tx;
    logic              r_miso;
    logic [7:0]        r_cmd;
    logic [7:0]        w_cmd_byte;
    logic [31:0]       w_data_word;
    logic [31:0]       w_rd_data;
    logic [7:0]        r_q_c;
    logic [31:0]       r_adc_cfg, r_dds_a_cfg, r_dds_b_cfg;
    logic [10:0]       r_mem_addr;
    logic [15:0]       r_mem_q;
    logic              r_dds_sel;
    logic [DDS_AW-1:0] r_dds_ptr;
    logic [7:0]        r_dds_a_data, r_dds_b_data;
    logic [DDS_AW-1:0] r_dds_a_addr, r_dds_b_addr;
    logic              r_dds_a_w, r_dds_b_w;

    assign w_mosi      = r_mosi_sync[1];
    assign w_sck_rise  =  r_sck_sync[1] & ~r_sck_d;
    assign w_sck_fall  = ~r_sck_sync[1] &  r_sck_d;
    assign w_ncs_fall  = ~r_ncs_sync[1] &  r_ncs_d;
    // The command byte and the data word are complete on the rise being
    // sampled now, so the current MOSI bit is appended to the shift register.
    assign w_cmd_byte  = {r_shift_in[6:0], w_mosi};
    assign w_data_word = {r_shift_in, w_mosi};

    // The raw chip select gates MISO so the line drops immediately on deselect.
    assign miso_spi      = r_miso & ~ncs_spi;
    assign q_c           = r_q_c;
    assign adc_cfg_out   = r_adc_cfg;
    assign dds_a_cfg_out = r_dds_a_cfg;
    assign dds_b_cfg_out = r_dds_b_cfg;
    assign mem_addr      = r_mem_addr;
    assign dds_a_data    = r_dds_a_data;
    assign dds_b_data    = r_dds_b_data;
    assign dds_a_addr    = r_dds_a_addr;
    assign dds_b_addr    = r_dds_b_addr;
    assign dds_a_w       = r_dds_a_w;
    assign dds_b_w       = r_dds_b_w;

    // Synchronizers and edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_ncs_sync  <= 2'b00;
            r_sck_d     <= 1'b0;
            r_ncs_d     <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[0], sck_spi};
            r_mosi_sync <= {r_mosi_sync[0], mosi_spi};
            r_ncs_sync  <= {r_ncs_sync[0], ncs_spi};
            r_sck_d     <= r_sck_sync[1];
            r_ncs_d     <= r_ncs_sync[1];
        end
    end

    // Command decode: the state that follows the command byte.
    always_comb begin
        w_dec_state = ST_IGN;
        case (w_cmd_byte[6:0])
            7'h00, 7'h02, 7'h03, 7'h04: w_dec_state = ST_CFG;
            7'h01: if (!w_cmd_byte[7]) w_dec_state = ST_BUF;
            7'h05, 7'h06: if (w_cmd_byte[7]) w_dec_state = ST_DDS;
            default: w_dec_state = ST_IGN;
        endcase
    end

    // Read data that is loaded behind the identity byte for config reads.
    always_comb begin
        w_rd_data = 32'h0;
`ifdef SPI_READBACK_EN
        if (!w_cmd_byte[7]) begin
            case (w_cmd_byte[6:0])
                7'h00:   w_rd_data = {24'h0, r_q_c};
                7'h02:   w_rd_data = r_adc_cfg;
                7'h03:   w_rd_data = r_dds_a_cfg;
                7'h04:   w_rd_data = r_dds_b_cfg;
                default: w_rd_data = 32'h0;
            endcase
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // A deselect in any state aborts the frame. A fresh select always restarts
    // at the command byte.
    always_comb begin
        w_state_nxt = r_state;
        if (w_ncs_fall) begin
            w_state_nxt = ST_CMD;
        end else if (r_ncs_sync[1]) begin
            w_state_nxt = ST_IDLE;
        end else if (w_sck_rise) begin
            case (r_state)
                ST_CMD:  if (r_bit_cnt == 5'd7)  w_state_nxt = w_dec_state;
                ST_CFG:  if (r_bit_cnt == 5'd31) w_state_nxt = ST_IGN;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= 5'd0;
            r_shift_in   <= 31'h0;
            r_tx         <= 32'h0;
            r_miso       <= 1'b0;
            r_cmd        <= 8'h0;
            r_q_c        <= 8'h0;
            r_adc_cfg    <= 32'h0;
            r_dds_a_cfg  <= 32'h0;
            r_dds_b_cfg  <= 32'h0;
            r_mem_addr   <= 11'd0;
            r_mem_q      <= 16'h0;
            r_dds_sel    <= 1'b0;
            r_dds_ptr    <= '0;
            r_dds_a_data <= 8'h0;
            r_dds_b_data <= 8'h0;
            r_dds_a_addr <= '0;
            r_dds_b_addr <= '0;
            r_dds_a_w    <= 1'b0;
            r_dds_b_w    <= 1'b0;
        end else begin
            r_dds_a_w <= 1'b0;
            r_dds_b_w <= 1'b0;
            // The data read for the address from the previous cycle is held
            // continuously, so the next word is always ready long before it
            // is needed.
            r_mem_q   <= mem_data;
            if (w_ncs_fall) begin
                // The first identity bit goes straight to MISO so it is valid
                // before the first sck rise. The rest wait in r_tx.
                r_bit_cnt <= 5'd0;
                r_miso    <= ID_BYTE[7];
                r_tx      <= {ID_BYTE[6:0], 25'h0};
                r_dds_ptr <= '0;
            end else if (r_state != ST_IDLE && !r_ncs_sync[1]) begin
                if (w_sck_fall) begin
                    r_miso <= r_tx[31];
                    r_tx   <= {r_tx[30:0], 1'b0};
                end
                if (w_sck_rise) begin
                    r_shift_in <= {r_shift_in[29:0], w_mosi};
                    r_bit_cnt  <= r_bit_cnt + 5'd1;
                    case (r_state)
                        ST_CMD: begin
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt <= 5'd0;
                                r_cmd     <= w_cmd_byte;
                                r_tx      <= 32'h0;
                                if (w_dec_state == ST_CFG) begin
                                    r_tx <= w_rd_data;
                                end else if (w_dec_state == ST_BUF) begin
                                    r_tx       <= {4'h0, trig_addr, 16'h0};
                                    r_mem_addr <= 11'd0;
                                end else if (w_dec_state == ST_DDS) begin
                                    r_dds_sel <= (w_cmd_byte[6:0] == 7'h06);
                                end
                            end
                        end
                        ST_CFG: begin
                            if (r_bit_cnt == 5'd31 && r_cmd[7]) begin
                                case (r_cmd[6:0])
                                    7'h00:   r_q_c       <= w_data_word[7:0];
                                    7'h02:   r_adc_cfg   <= w_data_word;
                                    7'h03:   r_dds_a_cfg <= w_data_word;
                                    7'h04:   r_dds_b_cfg <= w_data_word;
                                    default: r_q_c       <= r_q_c;
                                endcase
                            end
                        end
                        ST_BUF: begin
                            // A word has just been clocked out. Queue the next
                            // one for the fall that opens its slot.
                            if (r_bit_cnt == 5'd15) begin
                                r_bit_cnt  <= 5'd0;
                                r_tx       <= {r_mem_q, 16'h0};
                                r_mem_addr <= r_mem_addr + 11'd1;
                            end
                        end
                        ST_DDS: begin
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt <= 5'd0;
                                r_dds_ptr <= r_dds_ptr + 1'b1;
                                if (r_dds_sel) begin
                                    r_dds_b_data <= w_cmd_byte;
                                    r_dds_b_addr <= r_dds_ptr;
                                    r_dds_b_w    <= 1'b1;
                                end else begin
                                    r_dds_a_data <= w_cmd_byte;
                                    r_dds_a_addr <= r_dds_ptr;
                                    r_dds_a_w    <= 1'b1;
                                end
                            end
                        end
                        default: r_bit_cnt <= r_bit_cnt + 5'd1;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_module.sv
module tb_spi_module;
    localparam int AW   = 4;
    localparam int HALF = 52;
`ifdef SPI_READBACK_EN
    localparam logic [31:0] RB_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] RB_MASK = 32'h0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, mosi = 1'b0, ncs = 1'b1;
    logic miso;
    logic [7:0] q_c;
    logic [31:0] adc, dda, ddb;
    logic [15:0] mem_data = 16'h0;
    logic [10:0] mem_addr;
    logic [11:0] trig_addr = 12'hADF;
    logic [7:0] da_data, db_data;
    logic [AW-1:0] da_addr, db_addr;
    logic da_w, db_w;

    int n_tests = 0, n_fail = 0;
    logic [31:0] m_reg [0:4];
    logic [AW+7:0] qa[$], qb[$];

    spi_module #(.DDS_AW(AW), .ID_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .sck_spi(sck), .mosi_spi(mosi), .ncs_spi(ncs),
        .miso_spi(miso), .q_c(q_c), .adc_cfg_out(adc), .dds_a_cfg_out(dda),
        .dds_b_cfg_out(ddb), .mem_data(mem_data), .mem_addr(mem_addr),
        .trig_addr(trig_addr), .dds_a_data(da_data), .dds_b_data(db_data),
        .dds_a_addr(da_addr), .dds_b_addr(db_addr), .dds_a_w(da_w), .dds_b_w(db_w)
    );

    always #5 clk = ~clk;

    // Buffer memory with one clock of read latency.
    always @(posedge clk) mem_data <= {4'hE, 1'b0, mem_addr};

    always @(negedge clk) begin
        if (da_w) qa.push_back({da_addr, da_data});
        if (db_w) qb.push_back({db_addr, db_data});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " q_c"}, {24'h0, q_c}, 32'h0);
        check({tag, " adc"}, adc, 32'h0);
        check({tag, " dda"}, dda, 32'h0);
        check({tag, " ddb"}, ddb, 32'h0);
        check({tag, " mem_addr"}, {21'h0, mem_addr}, 32'h0);
        check({tag, " dds a"}, {20'h0, da_addr, da_data}, 32'h0);
        check({tag, " dds b"}, {20'h0, db_addr, db_data}, 32'h0);
        check({tag, " strobes"}, {30'h0, da_w, db_w}, 32'h0);
        check({tag, " miso"}, {31'h0, miso}, 32'h0);
    endtask

    task automatic spi_begin();
        @(negedge clk);
        ncs = 1'b0;
        #100;
    endtask

    task automatic spi_end();
        #HALF;
        ncs = 1'b1;
        #200;
    endtask

    // Mode 0 master: MISO sampled just before each rise, MSB first.
    task automatic spi_bits(input logic [31:0] tx, input int n, output logic [31:0] rx);
        rx = 32'h0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = tx[i];
            #HALF;
            rx = {rx[30:0], miso};
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
    endtask

    // Sends a command plus (nbits-8) leading data bits. nbits=40 is a full frame.
    task automatic cfg_frame(input logic [7:0] cmd, input logic [31:0] data, input int nbits,
                             output logic [7:0] id, output logic [31:0] rd);
        logic [31:0] r;
        spi_begin();
        spi_bits({24'h0, cmd}, 8, r);
        id = r[7:0];
        spi_bits(data >> (40 - nbits), nbits - 8, r);
        rd = r;
        spi_end();
    endtask

    function automatic logic [31:0] model_read(input logic [6:0] a);
        case (a)
            7'h00:          return {24'h0, m_reg[0][7:0]} & RB_MASK;
            7'h02, 7'h03, 7'h04: return m_reg[a[2:0]] & RB_MASK;
            default:        return 32'h0;
        endcase
    endfunction

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] data;
        int          nbits;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_q;
        logic [31:0] exp_adc, exp_dda, exp_ddb;
    } vec_t;

    vec_t vec [10];

    initial begin
        logic [7:0] id;
        logic [31:0] rd, r;
        vec[0] = '{8'h82, 32'h00112233, 40, 1'b0, 32'h0, 8'h00, 32'h00112233, 32'h0, 32'h0};
        vec[1] = '{8'h83, 32'hBABEFDCA, 40, 1'b0, 32'h0, 8'h00, 32'h00112233, 32'hBABEFDCA, 32'h0};
        vec[2] = '{8'h02, 32'h01234567, 40, 1'b1, 32'h00112233 & RB_MASK, 8'h00, 32'h00112233, 32'hBABEFDCA, 32'h0};
        vec[3] = '{8'h84, 32'hDEADBEEF, 20, 1'b0, 32'h0, 8'h00, 32'h00112233, 32'hBABEFDCA, 32'h0};
        vec[4] = '{8'h80, 32'h000000AB, 40, 1'b0, 32'h0, 8'hAB, 32'h00112233, 32'hBABEFDCA, 32'h0};
        vec[5] = '{8'h00, 32'hFFFFFFFF, 40, 1'b1, 32'h000000AB & RB_MASK, 8'hAB, 32'h00112233, 32'hBABEFDCA, 32'h0};
        vec[6] = '{8'h84, 32'h5555AAAA, 40, 1'b0, 32'h0, 8'hAB, 32'h00112233, 32'hBABEFDCA, 32'h5555AAAA};
        vec[7] = '{8'h04, 32'h0, 40, 1'b1, 32'h5555AAAA & RB_MASK, 8'hAB, 32'h00112233, 32'hBABEFDCA, 32'h5555AAAA};
        vec[8] = '{8'h07, 32'hFFFFFFFF, 40, 1'b1, 32'h0, 8'hAB, 32'h00112233, 32'hBABEFDCA, 32'h5555AAAA};
        vec[9] = '{8'h81, 32'h12345678, 40, 1'b1, 32'h0, 8'hAB, 32'h00112233, 32'hBABEFDCA, 32'h5555AAAA};

        #23;
        check_all_zero("reset");
        #20;
        rst_n = 1'b1;
        #200;

        for (int i = 0; i < 10; i++) begin
            cfg_frame(vec[i].cmd, vec[i].data, vec[i].nbits, id, rd);
            check($sformatf("vec%0d id", i), {24'h0, id}, 32'hA5);
            if (vec[i].chk_rd) check($sformatf("vec%0d rd", i), rd, vec[i].exp_rd);
            check($sformatf("vec%0d q_c", i), {24'h0, q_c}, {24'h0, vec[i].exp_q});
            check($sformatf("vec%0d adc", i), adc, vec[i].exp_adc);
            check($sformatf("vec%0d dda", i), dda, vec[i].exp_dda);
            check($sformatf("vec%0d ddb", i), ddb, vec[i].exp_ddb);
        end
        check("miso idle", {31'h0, miso}, 32'h0);

        // Randomized config traffic against the register model.
        m_reg[0] = {24'h0, vec[9].exp_q};
        m_reg[1] = 32'h0;
        m_reg[2] = vec[9].exp_adc;
        m_reg[3] = vec[9].exp_dda;
        m_reg[4] = vec[9].exp_ddb;
        for (int i = 0; i < 30; i++) begin
            logic [6:0] addrs [12];
            logic [6:0] a;
            logic w;
            logic [31:0] d;
            int nb;
            addrs = '{7'h00, 7'h02, 7'h03, 7'h04, 7'h00, 7'h02, 7'h03, 7'h04, 7'h07, 7'h08, 7'h45, 7'h01};
            a  = addrs[$urandom_range(0, 11)];
            w  = (a == 7'h01) ? 1'b1 : 1'($urandom_range(0, 1));
            d  = $urandom;
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 39)) : 40;
            cfg_frame({w, a}, d, nb, id, rd);
            check($sformatf("rnd%0d id", i), {24'h0, id}, 32'hA5);
            if (nb == 40 && !w) check($sformatf("rnd%0d rd", i), rd, model_read(a));
            if (nb == 40 && w && (a == 7'h01 || a > 7'h04)) check($sformatf("rnd%0d rd0", i), rd, 32'h0);
            if (nb == 40 && w) begin
                if (a == 7'h00) m_reg[0] = {24'h0, d[7:0]};
                else if (a >= 7'h02 && a <= 7'h04) m_reg[a[2:0]] = d;
            end
            check($sformatf("rnd%0d q_c", i), {24'h0, q_c}, m_reg[0]);
            check($sformatf("rnd%0d adc", i), adc, m_reg[2]);
            check($sformatf("rnd%0d dda", i), dda, m_reg[3]);
            check($sformatf("rnd%0d ddb", i), ddb, m_reg[4]);
        end

        // ADC buffer read: status then consecutive memory words.
        spi_begin();
        spi_bits(32'h01, 8, r);
        check("buf id", r, 32'hA5);
        for (int k = 0; k < 11; k++) begin
            spi_bits(32'h0, 16, r);
            check($sformatf("buf word%0d", k), r,
                  (k == 0) ? {20'h0, trig_addr} : {16'h0, 4'hE, 1'b0, 11'(k - 1)});
        end
        spi_end();
        check("buf mem_addr", {21'h0, mem_addr}, 32'd11);
        // A new buffer read restarts at address 0.
        trig_addr = 12'h123;
        spi_begin();
        spi_bits(32'h01, 8, r);
        spi_bits(32'h0, 16, r);
        check("buf2 status", r, 32'h0123);
        spi_bits(32'h0, 16, r);
        check("buf2 word1", r, 32'hE000);
        spi_end();

        // DDS A: two full bytes and a partial trailing byte.
        qa.delete();
        qb.delete();
        spi_begin();
        spi_bits(32'h85, 8, r);
        spi_bits(32'h11, 8, r);
        spi_bits(32'h22, 8, r);
        spi_bits(32'h5, 3, r);
        spi_end();
        check("ddsA count", qa.size(), 2);
        if (qa.size() == 2) begin
            check("ddsA wr0", {20'h0, qa[0]}, {20'h0, 4'd0, 8'h11});
            check("ddsA wr1", {20'h0, qa[1]}, {20'h0, 4'd1, 8'h22});
        end
        check("ddsA no B", qb.size(), 0);

        // DDS B: address wraps modulo the table size.
        qa.delete();
        qb.delete();
        spi_begin();
        spi_bits(32'h86, 8, r);
        for (int k = 0; k < 18; k++) spi_bits(32'h30 + k, 8, r);
        spi_end();
        check("ddsB count", qb.size(), 18);
        for (int k = 0; k < 18 && k < qb.size(); k++)
            check($sformatf("ddsB wr%0d", k), {20'h0, qb[k]}, {20'h0, 4'(k % 16), 8'(8'h30 + k)});
        check("ddsB no A", qa.size(), 0);

        // Reset in the middle of a frame.
        spi_begin();
        spi_bits(32'h82, 8, r);
        spi_bits(32'h123, 12, r);
        #7;
        rst_n = 1'b0;
        #3;
        check_all_zero("midreset");
        #100;
        rst_n = 1'b1;
        spi_bits(32'hFF, 8, r);
        spi_end();
        check("postreset adc", adc, 32'h0);
        cfg_frame(8'h82, 32'hCAFEF00D, 40, id, rd);
        check("postreset id", {24'h0, id}, 32'hA5);
        check("postreset adc wr", adc, 32'hCAFEF00D);
        cfg_frame(8'h02, 32'h0, 40, id, rd);
        check("postreset rd", rd, 32'hCAFEF00D & RB_MASK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
